// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : Fetch stage of the 8-bit core. Holds the PC and requests one
//            16-bit instruction word per fetch from program memory. The word
//            is latched into an instruction register (IR), and its fields are
//            decoded for the decode stage. The 6-bit immediate (imm_raw_o) and
//            is_6bits_o feed the downstream sign extender.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i          in   1        single clock, rising edge
//   reset_i        in   1        synchronous, active-high reset
//   mem_addr_o     out  PC_W     program memory address (current PC)
//   mem_req_o      out  1        fetch request, held until mem_ready_i
//   mem_ready_i    in   1        mem_rdata_i valid this cycle
//   mem_rdata_i    in   INSTR_W  fetched instruction word
//   redirect_i     in   1        taken branch/jump, highest priority event
//   redirect_pc_i  in   PC_W     new fetch address
//   instr_valid_o  out  1        instruction fields are valid
//   instr_ready_i  in   1        decode accepts the instruction this cycle
//   instr_pc_o     out  PC_W     address of the presented instruction
//   opcode_o       out  4        IR[15:12]
//   rs_o, rt_o     out  2 each   IR[11:10], IR[9:8]
//   imm_raw_o      out  6        IR[5:0], not extended
//   is_6bits_o     out  1        opcode[3:2] == 2'b01
//   halted_o       out  1        halt flag
// Configuration
//   IF_HALT_DETECT_EN : when defined, an accepted opcode 4'hF parks the stage
//                       in HALT until reset or redirect. When undefined,
//                       halted_o is tied to 0.
// ============================================================================
module instr_fetch #(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic [PC_W-1:0]    mem_addr_o,
  output logic               mem_req_o,
  input  logic               mem_ready_i,
  input  logic [INSTR_W-1:0] mem_rdata_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [PC_W-1:0]    instr_pc_o,
  output logic [3:0]         opcode_o,
  output logic [1:0]         rs_o,
  output logic [1:0]         rt_o,
  output logic [5:0]         imm_raw_o,
  output logic               is_6bits_o,
  output logic               halted_o
);

  localparam logic [PC_W-1:0] PC_INC = {{(PC_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    ipc_q, ipc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               ir_unused_bits;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      ipc_q   <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      ir_q    <= ir_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. A redirect overrides everything else. A coincident
  // mem_ready_i or instr_ready_i is dropped, so the IR and instr_pc keep
  // their old contents.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    ir_d    = ir_q;

    if (redirect_i) begin
      pc_d    = redirect_pc_i;
      state_d = ST_REQ;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_REQ;
        ST_REQ: begin
          if (mem_ready_i) begin
            ir_d    = mem_rdata_i;
            ipc_d   = pc_q;
            pc_d    = pc_q + PC_INC;   // wraps modulo 2^PC_W
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (instr_ready_i) begin
`ifdef IF_HALT_DETECT_EN
            // The halt opcode is only acted on once decode has taken it.
            state_d = (ir_q[15:12] == 4'hF) ? ST_HALT : ST_REQ;
`else
            state_d = ST_REQ;
`endif
          end
        end
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mem_addr_o    = pc_q;
  assign mem_req_o     = (state_q == ST_REQ);
  assign instr_valid_o = (state_q == ST_HOLD);
  assign instr_pc_o    = ipc_q;

  assign opcode_o      = ir_q[15:12];
  assign rs_o          = ir_q[11:10];
  assign rt_o          = ir_q[9:8];
  assign imm_raw_o     = ir_q[5:0];
  assign is_6bits_o    = (ir_q[15:14] == 2'b01);

  // IR[7:6] carries no field for this stage.
  assign ir_unused_bits = ^ir_q[7:6];

`ifdef IF_HALT_DETECT_EN
  assign halted_o = (state_q == ST_HALT);
`else
  assign halted_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Self-checking bench for instr_fetch. A transaction-level model
//            (fetch pointer, latched word, current phase) predicts every
//            output each cycle. The model is driven by directed scenarios and
//            a random phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  localparam logic [7:0] RST_PC = 8'h00;
`ifdef IF_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_rdata = 16'h0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = 8'h0;
  logic        instr_ready = 1'b0;

  logic [7:0]  mem_addr;
  logic        mem_req;
  logic        instr_valid;
  logic [7:0]  instr_pc;
  logic [3:0]  opcode;
  logic [1:0]  rs;
  logic [1:0]  rt;
  logic [5:0]  imm_raw;
  logic        is_6bits;
  logic        halted;

  always #5 clk = ~clk;

  instr_fetch #(
    .PC_W    (8),
    .INSTR_W (16),
    .RESET_PC(RST_PC)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .mem_addr_o   (mem_addr),
    .mem_req_o    (mem_req),
    .mem_ready_i  (mem_ready),
    .mem_rdata_i  (mem_rdata),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .instr_valid_o(instr_valid),
    .instr_ready_i(instr_ready),
    .instr_pc_o   (instr_pc),
    .opcode_o     (opcode),
    .rs_o         (rs),
    .rt_o         (rt),
    .imm_raw_o    (imm_raw),
    .is_6bits_o   (is_6bits),
    .halted_o     (halted)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [256];

  // Reference model. The phase values are: 0 = just out of reset,
  // 1 = fetching, 2 = presenting, 3 = halted.
  int          m_phase;
  logic [7:0]  m_pc;
  logic [7:0]  m_ipc;
  logic [15:0] m_ir;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic model_step();
    if (reset) begin
      m_phase = 0;
      m_pc    = RST_PC;
      m_ipc   = RST_PC;
      m_ir    = 16'h0000;
    end else if (redirect) begin
      m_pc    = redirect_pc;
      m_phase = 1;
    end else begin
      case (m_phase)
        0: m_phase = 1;
        1: if (mem_ready) begin
             m_ir    = mem[m_pc];
             m_ipc   = m_pc;
             m_pc    = 8'((int'(m_pc) + 1) % 256);
             m_phase = 2;
           end
        2: if (instr_ready)
             m_phase = (HALT_EN && (m_ir >> 12) == 16'hF) ? 3 : 1;
        default: ;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":mem_req"},     32'(mem_req),     32'(m_phase == 1));
    chk({tag, ":instr_valid"}, 32'(instr_valid), 32'(m_phase == 2));
    chk({tag, ":halted"},      32'(halted),      32'(m_phase == 3));
    if (m_phase == 1)
      chk({tag, ":mem_addr"},  32'(mem_addr),    32'(m_pc));
    chk({tag, ":instr_pc"},    32'(instr_pc),    32'(m_ipc));
    chk({tag, ":opcode"},      32'(opcode),      32'(m_ir >> 12));
    chk({tag, ":rs"},          32'(rs),          32'((m_ir >> 10) & 16'h3));
    chk({tag, ":rt"},          32'(rt),          32'((m_ir >> 8) & 16'h3));
    chk({tag, ":imm_raw"},     32'(imm_raw),     32'(m_ir & 16'h3F));
    chk({tag, ":is_6bits"},    32'(is_6bits),    32'((m_ir >> 14) == 16'h1));
  endtask

  // One clock: present memory data for the current address, advance the
  // model at the edge, then compare on the falling edge.
  task automatic cycle(input string tag);
    mem_rdata = mem_ready ? mem[mem_addr] : 16'($urandom);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic drive(input logic rdy, input logic irdy, input logic redir, input logic [7:0] rpc);
    mem_ready   = rdy;
    instr_ready = irdy;
    redirect    = redir;
    redirect_pc = rpc;
  endtask

  task automatic wait_req(input string tag, input int limit);
    int n = 0;
    while (mem_req !== 1'b1 && n < limit) begin
      cycle(tag);
      n++;
    end
    chk({tag, ":wait_req"}, 32'(mem_req), 32'h1);
  endtask

  task automatic wait_valid(input string tag, input int limit);
    int n = 0;
    while (instr_valid !== 1'b1 && n < limit) begin
      cycle(tag);
      n++;
    end
    chk({tag, ":wait_valid"}, 32'(instr_valid), 32'h1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h00] = 16'h5A3F;
    mem[8'h90] = 16'hF000;

    // Reset held for three cycles; a redirect during reset must be ignored.
    drive(1'b0, 1'b0, 1'b1, 8'h77);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cycle("reset");
    chk("reset_mem_req", 32'(mem_req), 32'h0);
    chk("reset_instr_pc", 32'(instr_pc), 32'(RST_PC));

    // First fetch from address 00 is stalled by decode for five cycles.
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    wait_valid("first_fetch", 8);
    chk("first_opcode",   32'(opcode),   32'h5);
    chk("first_rs",       32'(rs),       32'h2);
    chk("first_rt",       32'(rt),       32'h2);
    chk("first_imm",      32'(imm_raw),  32'h3F);
    chk("first_is6",      32'(is_6bits), 32'h1);
    chk("first_instr_pc", 32'(instr_pc), 32'h00);
    for (int i = 0; i < 5; i++) cycle("stall");

    // Streaming with both sides always ready: one instruction every 2 cycles.
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) cycle("stream");

    // Fetch at FF wraps to 00.
    drive(1'b0, 1'b0, 1'b1, 8'hFF);
    cycle("redir_ff");
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) cycle("wrap");

    // Redirect coincident with mem_ready: the word is dropped.
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    wait_req("pre_redir_mem", 6);
    drive(1'b1, 1'b0, 1'b1, 8'h40);
    cycle("redir_mem");
    chk("redir_mem_addr", 32'(mem_addr), 32'h40);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    wait_valid("after_redir", 6);
    chk("after_redir_pc", 32'(instr_pc), 32'h40);

    // Redirect coincident with instr_ready in HOLD: no transfer is counted.
    drive(1'b0, 1'b1, 1'b1, 8'h20);
    cycle("redir_hold");
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) cycle("post_redir_hold");

    // Opcode F: with halt detection it parks once accepted.
    drive(1'b0, 1'b0, 1'b1, 8'h90);
    cycle("redir_halt");
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    wait_valid("halt_fetch", 6);
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) cycle("halt_accept");
    reset = 1'b1;
    cycle("halt_reset");
    reset = 1'b0;
    chk("halt_reset_halted", 32'(halted), 32'h0);
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) cycle("post_halt");

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(99) == 0);
      drive(1'($urandom_range(1)), 1'($urandom_range(1)),
            ($urandom_range(19) == 0), 8'($urandom));
      cycle("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
